// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// Play controller for a 4x8 board: spawn, gravity, lock, repeated line-clear passes, line count, game over.
// Latency: registered outputs, 1 cycle after each transition; LOCK->SPAWN 2 cycles, +CLR_LAT+2 per clear pass.
// Backpressure: none; start/tick are dropped outside IDLE/FALL, and the clear unit is paced by a fixed CLR_LAT wait.
module game_sequencer #(
    parameter int CLR_LAT  = 2,
    parameter int MAX_PASS = 4
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        start,
    input  logic        tick,
    input  logic        collide,
    input  logic        spawn_blocked,
    input  logic [31:0] board_in,
    output logic [2:0]  state,
    output logic [1:0]  curr_piece,
    output logic        spawn,
    output logic        drop,
    output logic        lock,
    output logic        clr_go,
    output logic [7:0]  lines,
    output logic        game_over,
    output logic        error
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SPAWN = 3'd1;
    localparam logic [2:0] FALL  = 3'd2;
    localparam logic [2:0] LOCK  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;
    localparam logic [2:0] WAIT  = 3'd6;
    localparam logic [2:0] OVER  = 3'd7;

    localparam logic [3:0] MAX_PASS_C = 4'(MAX_PASS);
    localparam logic [3:0] WAIT_INIT  = 4'(CLR_LAT - 1);

    logic [2:0] state_nxt;
    logic [3:0] lfsr;
    logic [3:0] pass_cnt;
    logic [3:0] wait_cnt;
    logic       first;
    logic       full;
    logic [3:0] nfull;
    logic [8:0] lines_sum;
    logic       spawn_d;
    logic       drop_d;
    logic       lock_d;
    logic       clr_d;
    logic       over_d;

    // Row scan: flag any complete row and count how many are complete
    always_comb begin
        full  = 1'b0;
        nfull = 4'd0;
        for (int r = 0; r < 8; r++) begin
            if (board_in[31-4*r -: 4] == 4'hF) begin
                full  = 1'b1;
                nfull = nfull + 4'd1;
            end
        end
        lines_sum = {1'b0, lines} + {5'd0, nfull};
    end

    // State register
    always_ff @(posedge clka) begin
        if (!restart) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SPAWN;
            SPAWN:   state_nxt = spawn_blocked ? OVER : FALL;
            FALL:    if (tick && collide) state_nxt = LOCK;
            LOCK:    state_nxt = CHECK;
            CHECK: begin
                if (!full)                      state_nxt = SPAWN;
                else if (pass_cnt == MAX_PASS_C) state_nxt = OVER;
                else                            state_nxt = CLEAR;
            end
            CLEAR:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = CHECK;
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pulses fire on the cycle following the transition that names them
    always_comb begin
        spawn_d = (state == SPAWN) && !spawn_blocked;
        drop_d  = (state == FALL) && tick && !collide;
        lock_d  = (state == LOCK);
        clr_d   = (state == CLEAR);
        over_d  = (state_nxt == OVER);
    end

    // Output registers for the pulses and the game-over level
    always_ff @(posedge clka) begin
        if (!restart) begin
            spawn     <= 1'b0;
            drop      <= 1'b0;
            lock      <= 1'b0;
            clr_go    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            spawn     <= spawn_d;
            drop      <= drop_d;
            lock      <= lock_d;
            clr_go    <= clr_d;
            game_over <= over_d;
        end
    end

    // Datapath: piece generator, pass/wait counters, line count and sticky error
    always_ff @(posedge clka) begin
        if (!restart) begin
            lfsr       <= 4'b1001;
            curr_piece <= 2'd0;
            pass_cnt   <= 4'd0;
            wait_cnt   <= 4'd0;
            first      <= 1'b0;
            lines      <= 8'd0;
            error      <= 1'b0;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            case (state)
                SPAWN: if (!spawn_blocked) curr_piece <= lfsr[1:0];
                LOCK: begin
                    first    <= 1'b1;
                    pass_cnt <= 4'd0;
                end
                CHECK: begin
                    if (!full) begin
                        first <= 1'b0;
                    end else if (pass_cnt == MAX_PASS_C) begin
                        error <= 1'b1;
                    end else if (first) begin
                        // Only the first pass after a lock counts; later passes re-see the same rows
                        lines <= lines_sum[8] ? 8'hFF : lines_sum[7:0];
                        first <= 1'b0;
                    end
                end
                CLEAR: begin
                    wait_cnt <= WAIT_INIT;
                    pass_cnt <= pass_cnt + 4'd1;
                end
                WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
module tb_game_sequencer;

    logic        clka = 1'b0;
    logic        restart, start, tick, collide, spawn_blocked;
    logic [31:0] board_in;
    logic [2:0]  state;
    logic [1:0]  curr_piece;
    logic        spawn, drop, lock, clr_go;
    logic [7:0]  lines;
    logic        game_over, error;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(.CLR_LAT(2), .MAX_PASS(4)) dut (
        .clka(clka), .restart(restart), .start(start), .tick(tick), .collide(collide),
        .spawn_blocked(spawn_blocked), .board_in(board_in), .state(state), .curr_piece(curr_piece),
        .spawn(spawn), .drop(drop), .lock(lock), .clr_go(clr_go), .lines(lines),
        .game_over(game_over), .error(error)
    );

    always #5 clka = ~clka;

    // input bundle {restart, start, tick, collide, spawn_blocked}
    localparam logic [4:0] RST  = 5'b00000;
    localparam logic [4:0] NONE = 5'b10000;
    localparam logic [4:0] STRT = 5'b11000;
    localparam logic [4:0] TICK = 5'b10100;
    localparam logic [4:0] TC   = 5'b10110;
    localparam logic [4:0] COL  = 5'b10010;
    localparam logic [4:0] SB   = 5'b10001;
    localparam logic [4:0] STTK = 5'b11100;
    // pulse bundle {spawn, drop, lock, clr_go}
    localparam logic [3:0] P0 = 4'b0000;
    localparam logic [3:0] SP = 4'b1000;
    localparam logic [3:0] DR = 4'b0100;
    localparam logic [3:0] LK = 4'b0010;
    localparam logic [3:0] CL = 4'b0001;

    typedef struct {
        logic [4:0]  in;
        logic [31:0] bd;
        logic [16:0] eo;
        logic        pc_en;
        logic [1:0]  pc;
    } vec_t;

    typedef struct {
        logic [16:0] eo;
        logic        pc_en;
        logic [1:0]  pc;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    function automatic logic [16:0] pk(input logic [2:0] st, input logic [3:0] p, input logic [7:0] ln,
                                       input logic go, input logic er);
        return {st, p, ln, go, er};
    endfunction

    function automatic vec_t mk(input logic [4:0] in, input logic [31:0] bd, input logic [2:0] st,
                                input logic [3:0] p, input logic [7:0] ln, input logic go,
                                input logic er, input logic pce, input logic [1:0] pc);
        vec_t v;
        v.in = in; v.bd = bd; v.eo = pk(st, p, ln, go, er); v.pc_en = pce; v.pc = pc;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input logic [4:0] in, input logic [31:0] bd, input logic [16:0] eo,
                        input logic pce, input logic [1:0] pc, input string nm);
        exp_t e;
        exp_t g;
        logic [16:0] act;
        {restart, start, tick, collide, spawn_blocked} = in;
        board_in = bd;
        e.eo = eo; e.pc_en = pce; e.pc = pc; e.nm = nm;
        sb_q.push_back(e);
        @(posedge clka);
        #1;
        g = sb_q.pop_front();
        act = {state, spawn, drop, lock, clr_go, lines, game_over, error};
        checks++;
        if (act !== g.eo) begin
            failures++;
            $display("FAIL %s outputs{state,spawn,drop,lock,clr,lines,over,err} got=%h want=%h",
                     g.nm, act, g.eo);
        end
        if (g.pc_en) begin
            checks++;
            if (curr_piece !== g.pc) begin
                failures++;
                $display("FAIL %s curr_piece got=%b want=%b", g.nm, curr_piece, g.pc);
            end
        end
    endtask

    // One piece from FALL: lock, clear pass with board b, then back to FALL via spawn
    task automatic run_piece(input logic [31:0] b, input logic [7:0] lp, input logic [7:0] ln,
                             input string nm);
        step(TC,   32'h0, pk(3'd3, P0, lp, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_lockst"});
        step(NONE, 32'h0, pk(3'd4, LK, lp, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_check"});
        step(NONE, b,     pk(3'd5, P0, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_lines"});
        step(NONE, b,     pk(3'd6, CL, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_clrgo"});
        step(NONE, b,     pk(3'd6, P0, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_wait"});
        step(NONE, 32'h0, pk(3'd4, P0, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_recheck"});
        step(NONE, 32'h0, pk(3'd1, P0, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_respawn"});
        step(NONE, 32'h0, pk(3'd2, SP, ln, 1'b0, 1'b0), 1'b0, 2'd0, {nm, "_spawn"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lp;
        int ln;
        restart = 1'b0; start = 1'b0; tick = 1'b0; collide = 1'b0; spawn_blocked = 1'b0;
        board_in = 32'h0;

        // reset, start, spawn, drops, lock, no-clear respawn
        tbl.push_back(mk(RST,  32'h0, 3'd0, P0, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00));
        tbl.push_back(mk(STRT, 32'h0, 3'd1, P0, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00));
        tbl.push_back(mk(NONE, 32'h0, 3'd2, SP, 8'd0, 1'b0, 1'b0, 1'b1, 2'b11));
        tbl.push_back(mk(TICK, 32'h0, 3'd2, DR, 8'd0, 1'b0, 1'b0, 1'b1, 2'b11));
        tbl.push_back(mk(NONE, 32'h0, 3'd2, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(TICK, 32'h0, 3'd2, DR, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(TICK, 32'h0, 3'd2, DR, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(COL,  32'h0, 3'd2, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(TC,   32'h0, 3'd3, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(TICK, 32'h0, 3'd4, LK, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0, 3'd1, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0, 3'd2, SP, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00));
        // two bottom rows full, cleared after one pass
        tbl.push_back(mk(TC,   32'h0,  3'd3, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0,  3'd4, LK, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'hFF, 3'd5, P0, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'hFF, 3'd6, CL, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'hFF, 3'd6, P0, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'hFF, 3'd4, P0, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0,  3'd1, P0, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0,  3'd2, SP, 8'd2, 1'b0, 1'b0, 1'b1, 2'b01));
        // top row never clears: MAX_PASS passes, then error
        tbl.push_back(mk(TC,   32'h0, 3'd3, P0, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'h0, 3'd4, LK, 8'd2, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(NONE, 32'hF000_0000, 3'd5, P0, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int p = 0; p < 4; p++) begin
            tbl.push_back(mk(NONE, 32'hF000_0000, 3'd6, CL, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00));
            tbl.push_back(mk(NONE, 32'hF000_0000, 3'd6, P0, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00));
            tbl.push_back(mk(NONE, 32'hF000_0000, 3'd4, P0, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00));
            if (p < 3)
                tbl.push_back(mk(NONE, 32'hF000_0000, 3'd5, P0, 8'd3, 1'b0, 1'b0, 1'b0, 2'b00));
        end
        tbl.push_back(mk(NONE, 32'hF000_0000, 3'd7, P0, 8'd3, 1'b1, 1'b1, 1'b1, 2'b01));
        tbl.push_back(mk(STTK, 32'hF000_0000, 3'd7, P0, 8'd3, 1'b1, 1'b1, 1'b0, 2'b00));
        // reset from OVER, then blocked spawn
        tbl.push_back(mk(RST,  32'h0, 3'd0, P0, 8'd0, 1'b0, 1'b0, 1'b1, 2'b00));
        tbl.push_back(mk(STRT, 32'h0, 3'd1, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(SB,   32'h0, 3'd7, P0, 8'd0, 1'b1, 1'b0, 1'b1, 2'b00));
        tbl.push_back(mk(STTK, 32'h0, 3'd7, P0, 8'd0, 1'b1, 1'b0, 1'b0, 2'b00));
        tbl.push_back(mk(RST,  32'h0, 3'd0, P0, 8'd0, 1'b0, 1'b0, 1'b0, 2'b00));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].in, tbl[i].bd, tbl[i].eo, tbl[i].pc_en, tbl[i].pc, $sformatf("vec%0d", i));

        // saturation: 32 full-board pieces of 8 lines each, then a 2-line piece
        step(STRT, 32'h0, pk(3'd1, P0, 8'd0, 1'b0, 1'b0), 1'b0, 2'd0, "sat_start");
        step(NONE, 32'h0, pk(3'd2, SP, 8'd0, 1'b0, 1'b0), 1'b1, 2'b11, "sat_spawn");
        lp = 0;
        for (int k = 0; k < 32; k++) begin
            ln = (lp + 8 > 255) ? 255 : lp + 8;
            run_piece(32'hFFFF_FFFF, 8'(lp), 8'(ln), $sformatf("sat%0d", k));
            lp = ln;
        end
        run_piece(32'h0000_00FF, 8'd255, 8'd255, "sat_two");

        // reset in WAIT right after clr_go
        step(TC,   32'h0,  pk(3'd3, P0, 8'd255, 1'b0, 1'b0), 1'b0, 2'd0, "abort_lockst");
        step(NONE, 32'h0,  pk(3'd4, LK, 8'd255, 1'b0, 1'b0), 1'b0, 2'd0, "abort_check");
        step(NONE, 32'hFF, pk(3'd5, P0, 8'd255, 1'b0, 1'b0), 1'b0, 2'd0, "abort_clear");
        step(NONE, 32'hFF, pk(3'd6, CL, 8'd255, 1'b0, 1'b0), 1'b0, 2'd0, "abort_clrgo");
        step(RST,  32'hFF, pk(3'd0, P0, 8'd0,   1'b0, 1'b0), 1'b1, 2'b00, "abort_reset");
        step(STRT, 32'h0,  pk(3'd1, P0, 8'd0,   1'b0, 1'b0), 1'b0, 2'd0, "abort_start");
        step(NONE, 32'h0,  pk(3'd2, SP, 8'd0,   1'b0, 1'b0), 1'b1, 2'b11, "abort_lfsr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
